axi_lite_memory_mock: RTL and testbench
=======================================

Name: axi_lite_memory_mock

Overview:
- Simulation/FPGA-prototype memory model: AXI4-Lite slave serving one master (the riscv_cpu core).
- Holds two word-addressed arrays: instruction memory `i_data` and data memory `d_data`. Both are mapped into a single 32-bit address space.
- Benches preload the arrays through hierarchical `$readmemh` and check them directly after execution.

Parameters:
- ADDR_WIDTH, 32 (`AXI_ADDR_WIDTH`), AXI address width.
- DATA_WIDTH, 32 (`AXI_DATA_WIDTH`), AXI data width; WSTRB width is DATA_WIDTH/8.
- MEM_WORDS, `MEMORY_NUM_WORDS`, words per array.
- INSTR_BASE, 32'h0000_0000, byte base of `i_data`.
- DATA_BASE, 32'h0001_0000, byte base of `d_data`.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  synchronous active-low reset.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_AWADDR  in  ADDR_WIDTH  write byte address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_ARADDR  in  ADDR_WIDTH  read byte address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- S_AXI_RDATA  out  DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.

Behaviour:
- One clock CLK. Reset is synchronous, active-low on RSTn.
- Reset values: all READY/VALID outputs 0, RDATA 0, BRESP 00, RRESP 00.
- Reset never alters `i_data`/`d_data` contents. Contents are undefined until loaded; no initial clearing.
- Arrays are named exactly `i_data`/`d_data`, declared [0:MEM_WORDS-1] of DATA_WIDTH, word index = (addr-base)>>2.
- Address decode:
  - [INSTR_BASE, INSTR_BASE+4*MEM_WORDS) selects `i_data`.
  - [DATA_BASE, DATA_BASE+4*MEM_WORDS) selects `d_data`.
  - Anything else is unmapped. Address bits [1:0] are ignored.
- Write channel:
  - When AWVALID&&WVALID&&!BVALID&&!AWREADY, register AWREADY=WREADY=1 for exactly one cycle.
  - Handshake edge (AWVALID&&AWREADY): write the selected word honouring WSTRB per byte; set BVALID=1.
  - BRESP: 00 OKAY for `d_data` or `i_data`; 11 DECERR for unmapped, with no array modified.
  - BVALID held with BRESP stable until BREADY; cleared on the BVALID&&BREADY edge.
  - AW without W, or W without AW: wait, no ready.
  - Single outstanding write.
- Read channel:
  - When ARVALID&&!RVALID&&!ARREADY, register ARREADY=1 for one cycle.
  - On the handshake edge, register RDATA from the selected array and set RVALID=1. Data appears 1 cycle after the handshake.
  - RRESP: 00 mapped; 11 with RDATA=0 for unmapped.
  - RVALID, RDATA and RRESP held stable until RREADY; cleared on the RVALID&&RREADY edge.
  - Single outstanding read.
- Read and write channels are fully independent and may handshake in the same cycle.
- Read and write to the same word on the same edge: read returns pre-write data.
- Reset asserted mid-transaction: outstanding B/R responses are dropped and all VALID/READY outputs go to 0 next edge. A write whose handshake edge coincides with reset is not performed.
- WSTRB=0000 with a mapped address: no data change, BRESP OKAY.

Decomposition:
- Shared package/include (rv32i params, axi_configuration):
  - AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_STROBE_WIDTH.
  - MEMORY_NUM_WORDS, BYTES_PER_WORD.
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- A single optional sub-module `axi_lite_addr_decode`: address in → region select, word index, mapped flag; used by both channels. All else stays in one module.

Test Plan:
- Reset: hold RSTn=0 two cycles with AWVALID/ARVALID=1.
  - All READY/VALID stay 0.
  - Preloaded d_data[3]=32'hCAFEBABE unchanged after release.
- Instruction fetch: i_data[1]=32'h00500293; AR 0x00000004.
  - ARREADY pulses one cycle.
  - RVALID next cycle with RDATA=00500293, RRESP=00.
  - With RREADY held low 3 cycles, RVALID/RDATA stay stable.
- Byte-strobed store: d_data[2]=0; AW 0x00010008, WDATA 32'h11223344, WSTRB 4'b0010.
  - d_data[2]=32'h00003300.
  - BVALID one cycle after handshake, BRESP=00, cleared after BREADY.
- Full-word store then load: write 0xDEADBEEF to 0x00010000, then read it back.
  - RDATA=DEADBEEF.
  - With simultaneous AR/AW to 0x00010004 (old 0x1, new 0x2): read returns 0x1, memory becomes 0x2.
- Unmapped: read 0x00050000 → RRESP=11, RDATA=0. Write to the same address → BRESP=11, no array word changes.
- Write with AWVALID alone for 5 cycles, WVALID arriving later: no AWREADY until both valid, then normal completion.

Source files
------------

// File: rtl/axi_lite_memory_mock_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_memory_mock_pkg
// Shared AXI4-Lite configuration and memory-map constants for the memory mock
// and its address decoder.
// Contents:
//   AXI_ADDR_WIDTH / AXI_DATA_WIDTH / AXI_STROBE_WIDTH : bus geometry
//   MEMORY_NUM_WORDS / BYTES_PER_WORD                  : array geometry
//   RESP_*                                             : AXI response codes
//   region_t                                           : decoded target array
// -----------------------------------------------------------------------------
package axi_lite_memory_mock_pkg;

   localparam int AXI_ADDR_WIDTH   = 32;
   localparam int AXI_DATA_WIDTH   = 32;
   localparam int AXI_STROBE_WIDTH = AXI_DATA_WIDTH / 8;

   localparam int MEMORY_NUM_WORDS = 1024;
   localparam int BYTES_PER_WORD   = AXI_DATA_WIDTH / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Which backing array an address lands in.
   typedef enum logic [1:0] {
      REGION_NONE  = 2'd0,
      REGION_INSTR = 2'd1,
      REGION_DATA  = 2'd2
   } region_t;

endpackage

// File: rtl/axi_lite_memory_mock_addr_decode.sv
// -----------------------------------------------------------------------------
// axi_lite_addr_decode
// Maps a byte address onto one of the two word arrays of the memory mock.
// Ports:
//   i_addr    in   ADDR_WIDTH  byte address (bits [1:0] ignored)
//   o_region  out  2           region_t code: none / instruction / data
//   o_index   out  IDX_W       word index within the selected array
//   o_mapped  out  1           address hits one of the arrays
// -----------------------------------------------------------------------------
module axi_lite_addr_decode
   import axi_lite_memory_mock_pkg::*;
#(
   parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
   parameter int                    MEM_WORDS  = MEMORY_NUM_WORDS,
   parameter logic [ADDR_WIDTH-1:0] INSTR_BASE = 32'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0] DATA_BASE  = 32'h0001_0000,
   parameter int                    IDX_W      = $clog2(MEM_WORDS)
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [1:0]            o_region,
   output logic [IDX_W-1:0]      o_index,
   output logic                  o_mapped
);

   localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(BYTES_PER_WORD * MEM_WORDS);

   logic [ADDR_WIDTH-1:0] w_off_instr;
   logic [ADDR_WIDTH-1:0] w_off_data;
   logic [ADDR_WIDTH-1:0] w_off_sel;
   logic                  w_in_instr;
   logic                  w_in_data;
   logic                  w_unused;

   // Offset compare after subtraction keeps the window test free of overflow
   // at the top of the address space; the >= guard rejects wrap-around.
   assign w_off_instr = i_addr - INSTR_BASE;
   assign w_off_data  = i_addr - DATA_BASE;
   assign w_in_instr  = (i_addr >= INSTR_BASE) && (w_off_instr < SPAN);
   assign w_in_data   = (i_addr >= DATA_BASE)  && (w_off_data  < SPAN);

   // NOTE: every output of a combinational block gets a default first so that
   // no path through the branches leaves it unassigned (which would infer a latch).
   always_comb begin
      o_region  = REGION_NONE;
      w_off_sel = '0;
      if (w_in_instr) begin
         o_region  = REGION_INSTR;
         w_off_sel = w_off_instr;
      end else if (w_in_data) begin
         o_region  = REGION_DATA;
         w_off_sel = w_off_data;
      end
   end

   assign o_index  = w_off_sel[IDX_W+1:2];
   assign o_mapped = (o_region != REGION_NONE);

   // Byte-lane bits and bits above the window do not select a word.
   assign w_unused = ^{w_off_sel[ADDR_WIDTH-1:IDX_W+2], w_off_sel[1:0]};

endmodule

// File: rtl/axi_lite_memory_mock.sv
// -----------------------------------------------------------------------------
// axi_lite_memory_mock
// AXI4-Lite slave holding two word arrays, i_data (instruction) and d_data
// (data), for simulation and FPGA prototyping of a single master. Benches load
// and inspect the arrays hierarchically; reset never touches their contents.
// Ports:
//   CLK, RSTn                        clock (rising) / synchronous active-low reset
//   S_AXI_AW{VALID,READY,ADDR,PROT}  write address channel (PROT ignored)
//   S_AXI_W{VALID,READY,DATA,STRB}   write data channel, byte strobes honoured
//   S_AXI_B{VALID,READY,RESP}        write response: OKAY mapped, DECERR unmapped
//   S_AXI_AR{VALID,READY,ADDR,PROT}  read address channel (PROT ignored)
//   S_AXI_R{VALID,READY,DATA,RESP}   read data: DECERR with zero data if unmapped
// One outstanding transaction per channel; the channels are independent.
// -----------------------------------------------------------------------------
module axi_lite_memory_mock
   import axi_lite_memory_mock_pkg::*;
#(
   parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
   parameter int                    DATA_WIDTH = AXI_DATA_WIDTH,
   parameter int                    MEM_WORDS  = MEMORY_NUM_WORDS,
   parameter logic [ADDR_WIDTH-1:0] INSTR_BASE = 32'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0] DATA_BASE  = 32'h0001_0000
) (
   input  logic                    CLK,
   input  logic                    RSTn,
   input  logic                    S_AXI_AWVALID,
   output logic                    S_AXI_AWREADY,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]              S_AXI_AWPROT,
   input  logic                    S_AXI_WVALID,
   output logic                    S_AXI_WREADY,
   input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   output logic                    S_AXI_BVALID,
   input  logic                    S_AXI_BREADY,
   output logic [1:0]              S_AXI_BRESP,
   input  logic                    S_AXI_ARVALID,
   output logic                    S_AXI_ARREADY,
   input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]              S_AXI_ARPROT,
   output logic                    S_AXI_RVALID,
   input  logic                    S_AXI_RREADY,
   output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]              S_AXI_RRESP
);

   localparam int IDX_W  = $clog2(MEM_WORDS);
   localparam int STRB_W = DATA_WIDTH / 8;

   // Backing arrays; names and shape are relied upon by benches.
   logic [DATA_WIDTH-1:0] i_data [0:MEM_WORDS-1];
   logic [DATA_WIDTH-1:0] d_data [0:MEM_WORDS-1];

   logic                  r_awready;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;
   logic                  r_arready;
   logic                  r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp;

   logic [1:0]            w_aw_region;
   logic [IDX_W-1:0]      w_aw_index;
   logic                  w_aw_mapped;
   logic [1:0]            w_ar_region;
   logic [IDX_W-1:0]      w_ar_index;
   logic                  w_ar_mapped;
   logic                  w_wr_fire;
   logic                  w_rd_fire;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic                  w_unused;

   axi_lite_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_WORDS  (MEM_WORDS),
      .INSTR_BASE (INSTR_BASE),
      .DATA_BASE  (DATA_BASE),
      .IDX_W      (IDX_W)
   ) u_aw_decode (
      .i_addr   (S_AXI_AWADDR),
      .o_region (w_aw_region),
      .o_index  (w_aw_index),
      .o_mapped (w_aw_mapped)
   );

   axi_lite_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_WORDS  (MEM_WORDS),
      .INSTR_BASE (INSTR_BASE),
      .DATA_BASE  (DATA_BASE),
      .IDX_W      (IDX_W)
   ) u_ar_decode (
      .i_addr   (S_AXI_ARADDR),
      .o_region (w_ar_region),
      .o_index  (w_ar_index),
      .o_mapped (w_ar_mapped)
   );

   // AWREADY and WREADY are one register: both channels are accepted together.
   assign w_wr_fire = S_AXI_AWVALID && r_awready;
   assign w_rd_fire = S_AXI_ARVALID && r_arready;

   // ---------------------------------------------------------------- write --
   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register here sees the pre-edge values of the others.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         // Single-cycle ready pulse, only once both halves of the write are present.
         r_awready <= S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid && !r_awready;
         if (w_wr_fire) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_aw_mapped ? RESP_OKAY : RESP_DECERR;
         end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // NOTE: the arrays have no reset branch; their contents survive reset and
   // stay whatever the bench loaded. A write coinciding with reset is dropped.
   always_ff @(posedge CLK) begin
      if (RSTn && w_wr_fire) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (S_AXI_WSTRB[b]) begin
               if (w_aw_region == REGION_INSTR)
                  i_data[w_aw_index][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
               else if (w_aw_region == REGION_DATA)
                  d_data[w_aw_index][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
         end
      end
   end

   // ----------------------------------------------------------------- read --
   always_comb begin
      w_rd_word = '0;
      if (w_ar_region == REGION_INSTR)
         w_rd_word = i_data[w_ar_index];
      else if (w_ar_region == REGION_DATA)
         w_rd_word = d_data[w_ar_index];
   end

   // Reading the arrays here sees pre-edge contents, so a same-edge write to
   // the same word is not visible to this read.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_arready <= S_AXI_ARVALID && !r_rvalid && !r_arready;
         if (w_rd_fire) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_ar_mapped ? w_rd_word : '0;
            r_rresp  <= w_ar_mapped ? RESP_OKAY : RESP_DECERR;
         end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
         end
      end
   end

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_awready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;

   // Protection attributes carry no meaning for this model.
   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

endmodule

// File: tb/tb_axi_lite_memory_mock.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_memory_mock
// Directed bench for axi_lite_memory_mock: reset behaviour, instruction fetch
// with back-pressure, strobed and full-word stores, concurrent read/write to
// one word, unmapped accesses, window boundaries, reset during a handshake and
// a write whose data arrives late.
// -----------------------------------------------------------------------------
module tb_axi_lite_memory_mock;
   import axi_lite_memory_mock_pkg::*;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 CLK = ~CLK;

   axi_lite_memory_mock dut (
      .CLK           (CLK),
      .RSTn          (RSTn),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Full read transaction; RREADY is held low for 'hold' cycles once RVALID is up.
   task automatic do_read(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp,
                          input int hold);
      int n = 0;
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      @(negedge CLK);
      while (!S_AXI_ARREADY && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check({tag, "_arready"}, 32'(S_AXI_ARREADY), 32'd1);
      check({tag, "_rvalid_early"}, 32'(S_AXI_RVALID), 32'd0);
      @(negedge CLK);
      S_AXI_ARVALID = 1'b0;
      check({tag, "_arready_pulse"}, 32'(S_AXI_ARREADY), 32'd0);
      check({tag, "_rvalid"}, 32'(S_AXI_RVALID), 32'd1);
      check({tag, "_rdata"}, S_AXI_RDATA, exp_data);
      check({tag, "_rresp"}, 32'(S_AXI_RRESP), 32'(exp_resp));
      for (int i = 0; i < hold; i++) begin
         @(negedge CLK);
         check({tag, "_hold"}, {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA[28:0]},
               {1'b1, exp_resp, exp_data[28:0]});
      end
      S_AXI_RREADY = 1'b1;
      @(negedge CLK);
      S_AXI_RREADY = 1'b0;
      check({tag, "_rvalid_clr"}, 32'(S_AXI_RVALID), 32'd0);
   endtask

   // Full write transaction; AW and W are presented together (AWVALID may already be up).
   task automatic do_write(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp);
      int n = 0;
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      @(negedge CLK);
      while (!S_AXI_AWREADY && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check({tag, "_ready"}, {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd3);
      check({tag, "_bvalid_early"}, 32'(S_AXI_BVALID), 32'd0);
      @(negedge CLK);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      check({tag, "_ready_pulse"}, 32'(S_AXI_AWREADY), 32'd0);
      check({tag, "_bvalid"}, 32'(S_AXI_BVALID), 32'd1);
      check({tag, "_bresp"}, 32'(S_AXI_BRESP), 32'(exp_resp));
      S_AXI_BREADY = 1'b1;
      @(negedge CLK);
      S_AXI_BREADY = 1'b0;
      check({tag, "_bvalid_clr"}, 32'(S_AXI_BVALID), 32'd0);
   endtask

   initial begin
      int n;
      RSTn          = 1'b0;
      S_AXI_AWPROT  = 3'b000;
      S_AXI_ARPROT  = 3'b000;
      S_AXI_BREADY  = 1'b0;
      S_AXI_RREADY  = 1'b0;
      // Reset with both address channels requesting.
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      S_AXI_ARVALID = 1'b1;
      S_AXI_AWADDR  = 32'h0001_000C;
      S_AXI_ARADDR  = 32'h0001_000C;
      S_AXI_WDATA   = 32'hFFFF_FFFF;
      S_AXI_WSTRB   = 4'hF;

      dut.d_data[0]    <= 32'h0000_0000;
      dut.d_data[1]    <= 32'h0000_0001;
      dut.d_data[2]    <= 32'h0000_0000;
      dut.d_data[3]    <= 32'hCAFE_BABE;
      dut.d_data[1023] <= 32'h5A5A_0001;
      dut.i_data[1]    <= 32'h0050_0293;
      dut.i_data[2]    <= 32'h0000_0000;

      repeat (2) begin
         @(negedge CLK);
         check("rst_ready_valid",
               {27'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID},
               32'd0);
      end
      check("rst_rdata", S_AXI_RDATA, 32'd0);
      check("rst_resp", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_ARVALID = 1'b0;
      RSTn          = 1'b1;
      @(negedge CLK);
      check("rst_keeps_mem", dut.d_data[3], 32'hCAFE_BABE);

      // Instruction fetch with RREADY held off three cycles.
      do_read("ifetch", 32'h0000_0004, 32'h0050_0293, RESP_OKAY, 3);

      // Byte lane 1 only: 0x33 lands in bits [15:8].
      do_write("bstore", 32'h0001_0008, 32'h1122_3344, 4'b0010, RESP_OKAY);
      check("bstore_mem", dut.d_data[2], 32'h0000_3300);

      // No strobes: response OKAY, word untouched.
      do_write("nostrb", 32'h0001_0008, 32'hFFFF_FFFF, 4'b0000, RESP_OKAY);
      check("nostrb_mem", dut.d_data[2], 32'h0000_3300);

      do_write("word_wr", 32'h0001_0000, 32'hDEAD_BEEF, 4'hF, RESP_OKAY);
      do_read("word_rd", 32'h0001_0000, 32'hDEAD_BEEF, RESP_OKAY, 0);

      // Store into the instruction array must not touch d_data[2].
      do_write("istore", 32'h0000_0008, 32'h0000_0013, 4'hF, RESP_OKAY);
      check("istore_mem", dut.i_data[2], 32'h0000_0013);
      check("istore_dmem", dut.d_data[2], 32'h0000_3300);

      // Last data word, address low bits set; one past the window is unmapped.
      do_read("top_word", 32'h0001_0FFF, 32'h5A5A_0001, RESP_OKAY, 0);
      do_read("past_top", 32'h0001_1000, 32'h0000_0000, RESP_DECERR, 0);

      // Concurrent read and write of the same word: read sees the old value.
      S_AXI_AWADDR  = 32'h0001_0004;
      S_AXI_ARADDR  = 32'h0001_0004;
      S_AXI_WDATA   = 32'h0000_0002;
      S_AXI_WSTRB   = 4'hF;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      S_AXI_ARVALID = 1'b1;
      n = 0;
      @(negedge CLK);
      while (!(S_AXI_AWREADY && S_AXI_ARREADY) && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check("rw_ready", {30'd0, S_AXI_AWREADY, S_AXI_ARREADY}, 32'd3);
      @(negedge CLK);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_ARVALID = 1'b0;
      check("rw_valids", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd3);
      check("rw_old_data", S_AXI_RDATA, 32'h0000_0001);
      check("rw_resps", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
      check("rw_new_mem", dut.d_data[1], 32'h0000_0002);
      S_AXI_BREADY = 1'b1;
      S_AXI_RREADY = 1'b1;
      @(negedge CLK);
      S_AXI_BREADY = 1'b0;
      S_AXI_RREADY = 1'b0;
      check("rw_clr", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);

      // Unmapped address: DECERR on both channels, no array word altered.
      do_read("unm_rd", 32'h0005_0000, 32'h0000_0000, RESP_DECERR, 1);
      do_write("unm_wr", 32'h0005_0000, 32'hAAAA_AAAA, 4'hF, RESP_DECERR);
      check("unm_d0", dut.d_data[0], 32'hDEAD_BEEF);
      check("unm_d1", dut.d_data[1], 32'h0000_0002);
      check("unm_d3", dut.d_data[3], 32'hCAFE_BABE);
      check("unm_i0", dut.i_data[1], 32'h0050_0293);

      // Reset lands on the write handshake edge: write dropped, outputs idle.
      S_AXI_AWADDR  = 32'h0001_000C;
      S_AXI_WDATA   = 32'h1234_5678;
      S_AXI_WSTRB   = 4'hF;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      n = 0;
      @(negedge CLK);
      while (!S_AXI_AWREADY && n < 20) begin
         @(negedge CLK);
         n++;
      end
      check("mid_rst_ready", 32'(S_AXI_AWREADY), 32'd1);
      RSTn = 1'b0;
      @(negedge CLK);
      check("mid_rst_outs",
            {27'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID},
            32'd0);
      check("mid_rst_mem", dut.d_data[3], 32'hCAFE_BABE);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      RSTn          = 1'b1;
      @(negedge CLK);

      // AW alone for five cycles: no ready until W arrives.
      S_AXI_AWADDR  = 32'h0001_000C;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         check("aw_only_wait", {30'd0, S_AXI_AWREADY, S_AXI_BVALID}, 32'd0);
      end
      do_write("late_w", 32'h0001_000C, 32'h0BAD_F00D, 4'hF, RESP_OKAY);
      check("late_w_mem", dut.d_data[3], 32'h0BAD_F00D);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
